// File: rtl/bit_destuffer.sv
// Receive-side bit destuffer: tracks equal-bit runs, flags stuff bits,
// detects stuff errors and emits the destuffed stream plus SOF pulse.
module bit_destuffer #(
  parameter int STUFF_LEN = 5,
  parameter int EOF_LEN   = 7,
  parameter int IDLE_LEN  = 11
) (
  input  logic sp,
  input  logic reset,
  input  logic rxBit,
  input  logic stuffEn,
  output logic isStuff,
  output logic bitOut,
  output logic bitValid,
  output logic sofDet,
  output logic stuffErr
);

  localparam int RUN_W = $clog2(STUFF_LEN) + 1;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STUFF_LEN);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
  localparam logic [3:0] REC_MAX = 4'(IDLE_LEN);
  localparam logic [3:0] REC_EOF = 4'(EOF_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_TAIL,
    S_ERROR
  } state_t;

  state_t           state_q, state_d;
  logic             stuff_q, stuff_d;
  logic             bit_out_q, bit_out_d;
  logic             valid_q, valid_d;
  logic             sof_q, sof_d;
  logic             err_q, err_d;
  logic             last_q, last_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [3:0]       rec_q, rec_d;

  logic [RUN_W-1:0] run_next;
  logic [3:0]       rec_next;
  logic             same_bit;

  assign same_bit = (rxBit == last_q);

  // Both counters saturate so they can never wrap back into range.
  always_comb begin
    run_next = RUN_ONE;
    if (same_bit) begin
      run_next = (run_q >= RUN_MAX) ? RUN_MAX : run_q + RUN_ONE;
    end
    rec_next = 4'd0;
    if (rxBit) begin
      rec_next = (rec_q >= REC_MAX) ? REC_MAX : rec_q + 4'd1;
    end
  end

  always_ff @(posedge sp or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      stuff_q   <= 1'b0;
      bit_out_q <= 1'b0;
      valid_q   <= 1'b0;
      sof_q     <= 1'b0;
      err_q     <= 1'b0;
      last_q    <= 1'b1;
      run_q     <= '0;
      rec_q     <= 4'd0;
    end else begin
      state_q   <= state_d;
      stuff_q   <= stuff_d;
      bit_out_q <= bit_out_d;
      valid_q   <= valid_d;
      sof_q     <= sof_d;
      err_q     <= err_d;
      last_q    <= last_d;
      run_q     <= run_d;
      rec_q     <= rec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (!rxBit) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (stuff_q) begin
          if (same_bit) state_d = S_ERROR;
        end else if (!stuffEn) begin
          state_d = S_TAIL;
        end
      end
      S_TAIL: begin
        if (rec_next >= REC_EOF) state_d = S_IDLE;
      end
      S_ERROR: begin
        if (rec_next >= REC_MAX) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stuff_d   = 1'b0;
    bit_out_d = bit_out_q;
    valid_d   = 1'b0;
    sof_d     = 1'b0;
    err_d     = 1'b0;
    last_d    = last_q;
    run_d     = run_q;
    rec_d     = rec_q;
    unique case (state_q)
      S_IDLE: begin
        if (!rxBit) begin
          sof_d     = 1'b1;
          bit_out_d = 1'b0;
          valid_d   = 1'b1;
          last_d    = 1'b0;
          run_d     = RUN_ONE;
        end
      end
      S_ACTIVE: begin
        if (stuff_q) begin
          // A stuff bit must differ; when it does it opens the next run.
          if (same_bit) begin
            err_d = 1'b1;
            rec_d = {3'd0, rxBit};
          end else begin
            last_d = rxBit;
            run_d  = RUN_ONE;
          end
        end else begin
          bit_out_d = rxBit;
          valid_d   = 1'b1;
          last_d    = rxBit;
          run_d     = run_next;
          if (stuffEn && run_next == RUN_MAX) begin
            stuff_d = 1'b1;
          end else if (!stuffEn) begin
            rec_d = {3'd0, rxBit};
          end
        end
      end
      S_TAIL: begin
        bit_out_d = rxBit;
        valid_d   = 1'b1;
        rec_d     = rec_next;
      end
      S_ERROR: begin
        rec_d = rec_next;
      end
      default: ;
    endcase
  end

  assign isStuff  = stuff_q;
  assign bitOut   = bit_out_q;
  assign bitValid = valid_q;
  assign sofDet   = sof_q;
  assign stuffErr = err_q;

endmodule
